arccos_x: RTL and testbench



---
 rtl/arccos_x.sv | 260 ++++++++++++++++++++++++++
 tb/tb_arccos_x.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arccos_x.sv
// arccos_x: sequential binary32 arccos using a Newton square root and an arcsin Taylor series on shared float ops.
// Define ACOS_RANGE_CHECK_EN to add the err output, which flags |x| > 1 with a NaN result.
module arccos_x #(
  parameter int TERMS      = 8,
  parameter int SQRT_ITERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] ketqua
`ifdef ACOS_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [31:0] F_ONE     = 32'h3F800000;
  localparam logic [31:0] F_HALF    = 32'h3F000000;
  localparam logic [31:0] F_PI      = 32'h40490FDB;
  localparam logic [31:0] F_HALF_PI = 32'h3FC90FDB;
`ifdef ACOS_RANGE_CHECK_EN
  localparam logic [31:0] F_NAN     = 32'h7FC00000;
`endif

  typedef enum logic [2:0] {IDLE, CLASS, SQRT, SERIES, FINAL, DONE} state_t;

  // Truncating float add: 3 guard bits during alignment, no rounding, zero treated as identity.
  function automatic logic [31:0] fAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [26:0] mBig, mSml, norm;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    d    = big[30:23] - sml[30:23];
    mBig = {1'b1, big[22:0], 3'b000};
    mSml = {1'b1, sml[22:0], 3'b000};
    mSml = (d > 8'd26) ? 27'd0 : (mSml >> d);
    if (big[31] == sml[31]) begin
      sum = {1'b0, mBig} + {1'b0, mSml};
      if (sum[27]) return {big[31], big[30:23] + 8'd1, sum[26:4]};
      return {big[31], big[30:23], sum[25:3]};
    end
    sum = {1'b0, mBig} - {1'b0, mSml};
    if (sum == 28'd0) return 32'd0;
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = 5'(26 - i);
      end
    end
    norm = sum[26:0] << lz;
    e    = {2'b00, big[30:23]} - {5'd0, lz};
    if (e[9] || e == 10'd0) return 32'd0;
    return {big[31], e[7:0], norm[25:3]};
  endfunction

  function automatic logic [31:0] fMul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [9:0]  e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, prod[47]};
    if (e[9] || e == 10'd0) return 32'd0;
    return {a[31] ^ b[31], e[7:0], prod[47] ? prod[46:24] : prod[45:23]};
  endfunction

  function automatic logic [31:0] fDiv(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] q;
    logic [9:0]  e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    q = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd126 + {9'd0, q[24]};
    if (e[9] || e == 10'd0) return 32'd0;
    return {a[31] ^ b[31], e[7:0], q[24] ? q[23:1] : q[22:0]};
  endfunction

  function automatic logic [31:0] fHalve(input logic [31:0] a);
    if (a[30:23] <= 8'd1) return 32'd0;
    return {a[31], a[30:23] - 8'd1, a[22:0]};
  endfunction

  function automatic logic [31:0] fDouble(input logic [31:0] a);
    if (a[30:23] == 8'd0) return 32'd0;
    return {a[31], a[30:23] + 8'd1, a[22:0]};
  endfunction

  // arcsin series coefficients (2k)! / (4^k (k!)^2 (2k+1)) as binary32
  function automatic logic [31:0] coefRom(input logic [2:0] k);
    case (k)
      3'd0:    return 32'h3F800000;
      3'd1:    return 32'h3E2AAAAB;
      3'd2:    return 32'h3D99999A;
      3'd3:    return 32'h3D36DB6E;
      3'd4:    return 32'h3CF8E38E;
      3'd5:    return 32'h3CB745D1;
      3'd6:    return 32'h3C8E2762;
      default: return 32'h3C64CCCD;
    endcase
  endfunction

  state_t      r_state, w_next;
  logic        r_sign, r_large;
  logic [31:0] r_a, r_t, r_y, r_acc, r_p, r_u2, r_ketqua;
  logic [2:0]  r_k, r_it;
`ifdef ACOS_RANGE_CHECK_EN
  logic        r_err;
`endif

  logic        w_over, w_one, w_tiny, w_small, w_special;
  logic [31:0] w_specVal, w_t, w_y0, w_yNext, w_u2Sqrt, w_u2Small;
  logic [31:0] w_accNext, w_pNext, w_twoAcc, w_final;
  logic signed [9:0] w_eHalf;

  assign w_over    = r_a > F_ONE;
  assign w_one     = r_a == F_ONE;
  assign w_tiny    = r_a[30:23] < 8'd107;
  assign w_small   = r_a <= F_HALF;
  assign w_special = w_over | w_one | w_tiny;

  always_comb begin
    w_specVal = F_HALF_PI;
    if (w_over || w_one) w_specVal = r_sign ? F_PI : 32'h00000000;
`ifdef ACOS_RANGE_CHECK_EN
    if (w_over) w_specVal = F_NAN;
`endif
  end

  // Large |x| uses acos(a) = 2*asin(sqrt((1-a)/2)); the seed is 2^floor(e_t/2).
  assign w_t       = fHalve(fAdd(F_ONE, {1'b1, r_a[30:0]}));
  assign w_eHalf   = $signed({2'b00, w_t[30:23]} - 10'd127) >>> 1;
  assign w_y0      = {1'b0, 8'(w_eHalf + 10'sd127), 23'd0};
  assign w_yNext   = fHalve(fAdd(r_y, fDiv(r_t, r_y)));
  assign w_u2Sqrt  = fMul(w_yNext, w_yNext);
  assign w_u2Small = fMul(r_a, r_a);
  assign w_accNext = fAdd(r_acc, fMul(coefRom(r_k), r_p));
  assign w_pNext   = fMul(r_p, r_u2);
  assign w_twoAcc  = fDouble(r_acc);

  always_comb begin
    w_final = 32'd0;
    case ({r_large, r_sign})
      2'b00:   w_final = fAdd(F_HALF_PI, {~r_acc[31], r_acc[30:0]});
      2'b01:   w_final = fAdd(F_HALF_PI, r_acc);
      2'b10:   w_final = w_twoAcc;
      default: w_final = fAdd(F_PI, {~w_twoAcc[31], w_twoAcc[30:0]});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_next = CLASS;
      CLASS: begin
        if (w_special)    w_next = DONE;
        else if (w_small) w_next = SERIES;
        else              w_next = SQRT;
      end
      SQRT:    if (r_it == 3'(SQRT_ITERS - 1)) w_next = SERIES;
      SERIES:  if (r_k == 3'(TERMS - 1)) w_next = FINAL;
      FINAL:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_large  <= 1'b0;
      r_a      <= 32'd0;
      r_t      <= 32'd0;
      r_y      <= 32'd0;
      r_acc    <= 32'd0;
      r_p      <= 32'd0;
      r_u2     <= 32'd0;
      r_ketqua <= 32'd0;
      r_k      <= 3'd0;
      r_it     <= 3'd0;
`ifdef ACOS_RANGE_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign <= x[31];
            r_a    <= {1'b0, x[30:0]};
          end
        end
        CLASS: begin
          if (w_special) begin
            r_ketqua <= w_specVal;
`ifdef ACOS_RANGE_CHECK_EN
            r_err    <= w_over;
`endif
          end else if (w_small) begin
            r_acc   <= 32'd0;
            r_p     <= r_a;
            r_u2    <= w_u2Small;
            r_k     <= 3'd0;
            r_large <= 1'b0;
          end else begin
            r_t     <= w_t;
            r_y     <= w_y0;
            r_it    <= 3'd0;
            r_large <= 1'b1;
          end
        end
        SQRT: begin
          r_y <= w_yNext;
          if (r_it == 3'(SQRT_ITERS - 1)) begin
            r_it  <= 3'd0;
            r_acc <= 32'd0;
            r_p   <= w_yNext;
            r_u2  <= w_u2Sqrt;
            r_k   <= 3'd0;
          end else begin
            r_it  <= r_it + 3'd1;
          end
        end
        SERIES: begin
          r_acc <= w_accNext;
          r_p   <= w_pNext;
          r_k   <= (r_k == 3'(TERMS - 1)) ? 3'd0 : r_k + 3'd1;
        end
        FINAL: begin
          r_ketqua <= w_final;
`ifdef ACOS_RANGE_CHECK_EN
          r_err    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ketqua = r_ketqua;
`ifdef ACOS_RANGE_CHECK_EN
  assign err    = r_err;
`endif

endmodule

// File: tb/tb_arccos_x.sv
// tb_arccos_x: directed bench for arccos_x with a real-arithmetic reference model.
// Exact bit patterns are expected for special cases, |error| <= 1e-5 against $acos otherwise.
module tb_arccos_x;

  localparam int TERMS      = 8;
  localparam int SQRT_ITERS = 4;
  localparam logic [31:0] PI_BITS      = 32'h40490FDB;
  localparam logic [31:0] HALF_PI_BITS = 32'h3FC90FDB;
  localparam real TOL = 1.0e-5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] ketqua;
`ifdef ACOS_RANGE_CHECK_EN
  logic        err;
`endif

  int compared   = 0;
  int mismatched = 0;
  int edgeCount  = 0;

  // Reference model state, written by the driver and read by the compare process
  bit          monitorOn   = 1'b0;
  int          expDoneEdge = -1;
  int          busyLo      = -1;
  int          busyHi      = -2;
  bit          expExact    = 1'b1;
  logic [31:0] expBits     = 32'd0;
  real         expReal     = 0.0;
  bit          expErr      = 1'b0;
  int          pinKind     = 0;
  logic [31:0] pinBits     = 32'd0;
  real         pinReal     = 0.0;
  bit          zeroCheck   = 1'b0;

  arccos_x #(.TERMS(TERMS), .SQRT_ITERS(SQRT_ITERS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .x(x),
    .busy(busy),
    .done(done),
    .ketqua(ketqua)
`ifdef ACOS_RANGE_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic real f2r(input logic [31:0] f);
    real m;
    if (f[30:23] == 8'd0) return 0.0;
    m = real'({1'b1, f[22:0]}) * (2.0 ** (real'(int'(f[30:23]) - 150)));
    return f[31] ? -m : m;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic checkOutput(input string name, input bit ok, input string actual, input string required);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %s, expected %s", name, edgeCount, actual, required);
    end
  endtask

  // What arccos must return for operand v, and how many cycles it may take.
  task automatic modelRequest(input logic [31:0] v, output int lat);
    logic [31:0] a;
    a        = {1'b0, v[30:0]};
    expExact = 1'b1;
    expBits  = 32'd0;
    expReal  = 0.0;
    expErr   = 1'b0;
    lat      = 2;
    if (a > 32'h3F800000) begin
`ifdef ACOS_RANGE_CHECK_EN
      expBits = 32'h7FC00000;
      expErr  = 1'b1;
`else
      expBits = v[31] ? PI_BITS : 32'h00000000;
`endif
    end else if (a == 32'h3F800000) begin
      expBits = v[31] ? PI_BITS : 32'h00000000;
    end else if (int'(a[30:23]) < 107) begin
      expBits = HALF_PI_BITS;
    end else begin
      expExact = 1'b0;
      expReal  = $acos(f2r(v));
      lat      = (a <= 32'h3F000000) ? TERMS + 3 : TERMS + SQRT_ITERS + 3;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] val, input int kind, input logic [31:0] pBits,
                               input real pReal, input int pulseA, input int pulseB);
    int c;
    int lat;
    @(negedge clk);
    c = edgeCount;
    modelRequest(val, lat);
    expDoneEdge = c + lat;
    busyLo      = c + 1;
    busyHi      = c + lat;
    pinKind     = kind;
    pinBits     = pBits;
    pinReal     = pReal;
    zeroCheck   = 1'b0;
    start       = 1'b1;
    x           = val;
    @(negedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      if (k == pulseA || k == pulseB) begin
        start = 1'b1;
        x     = 32'h3F800000;
      end else begin
        start = 1'b0;
        x     = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic resetMidRequest(input logic [31:0] val, input int atCycle);
    int c;
    int lat;
    @(negedge clk);
    c = edgeCount;
    modelRequest(val, lat);
    expDoneEdge = c + lat;
    busyLo      = c + 1;
    busyHi      = c + lat;
    pinKind     = 0;
    zeroCheck   = 1'b0;
    start       = 1'b1;
    x           = val;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < atCycle; k++) @(negedge clk);
    rst_n       = 1'b0;
    expDoneEdge = -1;
    busyLo      = -1;
    busyHi      = -2;
    zeroCheck   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Compare process: handshake every cycle, result on the done cycle and the one after it.
  initial begin
    real diff;
    bit  expBusy;
    bit  expDone;
    forever begin
      @(negedge clk);
      #1;
      if (monitorOn) begin
        expBusy = (edgeCount >= busyLo) && (edgeCount <= busyHi);
        expDone = (edgeCount == expDoneEdge);
        checkOutput("busy", busy == expBusy, $sformatf("%0b", busy), $sformatf("%0b", expBusy));
        checkOutput("done", done == expDone, $sformatf("%0b", done), $sformatf("%0b", expDone));
        if (expDoneEdge >= 0 && (edgeCount == expDoneEdge || edgeCount == expDoneEdge + 1)) begin
          if (expExact) begin
            checkOutput("ketqua", ketqua == expBits, $sformatf("%h", ketqua), $sformatf("%h", expBits));
          end else begin
            diff = absr(f2r(ketqua) - expReal);
            checkOutput("ketqua_acos", diff <= TOL, $sformatf("%h (%.7f)", ketqua, f2r(ketqua)),
                        $sformatf("%.7f within 1e-5", expReal));
          end
          if (pinKind == 1)
            checkOutput("pin_bits", ketqua == pinBits, $sformatf("%h", ketqua), $sformatf("%h", pinBits));
          if (pinKind == 2)
            checkOutput("pin_real", absr(f2r(ketqua) - pinReal) <= TOL,
                        $sformatf("%.7f", f2r(ketqua)), $sformatf("%.7f within 1e-5", pinReal));
`ifdef ACOS_RANGE_CHECK_EN
          checkOutput("err", err == expErr, $sformatf("%0b", err), $sformatf("%0b", expErr));
`endif
        end
        if (zeroCheck) begin
          checkOutput("reset_ketqua", ketqua == 32'd0, $sformatf("%h", ketqua), "00000000");
`ifdef ACOS_RANGE_CHECK_EN
          checkOutput("reset_err", err == 1'b0, $sformatf("%0b", err), "0");
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy == 1'b0, $sformatf("%0b", busy), "0");
    checkOutput("rst_done", done == 1'b0, $sformatf("%0b", done), "0");
    checkOutput("rst_ketqua", ketqua == 32'd0, $sformatf("%h", ketqua), "00000000");
`ifdef ACOS_RANGE_CHECK_EN
    checkOutput("rst_err", err == 1'b0, $sformatf("%0b", err), "0");
`endif
    rst_n     = 1'b1;
    monitorOn = 1'b1;

    applyStimulus(32'h00000000, 1, HALF_PI_BITS, 0.0, 0, 0);
    applyStimulus(32'h80000000, 1, HALF_PI_BITS, 0.0, 0, 0);
    applyStimulus(32'h3F000000, 2, 32'd0, 1.0471976, 0, 0);
    applyStimulus(32'hBF000000, 2, 32'd0, 2.0943951, 0, 0);
    applyStimulus(32'h3F666666, 2, 32'd0, 0.4510268, 0, 0);
    applyStimulus(32'hBF666666, 2, 32'd0, 2.6905658, 0, 0);
    applyStimulus(32'h3F800000, 1, 32'h00000000, 0.0, 0, 0);
    applyStimulus(32'hBF800000, 1, PI_BITS, 0.0, 0, 0);
`ifdef ACOS_RANGE_CHECK_EN
    applyStimulus(32'h3FC00000, 1, 32'h7FC00000, 0.0, 0, 0);
    applyStimulus(32'hBFC00000, 1, 32'h7FC00000, 0.0, 0, 0);
`else
    applyStimulus(32'h3FC00000, 1, 32'h00000000, 0.0, 0, 0);
    applyStimulus(32'hBFC00000, 1, PI_BITS, 0.0, 0, 0);
`endif
    applyStimulus(32'h3F000001, 0, 32'd0, 0.0, 0, 0);
    applyStimulus(32'h35800000, 0, 32'd0, 0.0, 0, 0);
    applyStimulus(32'h357FFFFF, 1, HALF_PI_BITS, 0.0, 0, 0);
    applyStimulus(32'hB57FFFFF, 1, HALF_PI_BITS, 0.0, 0, 0);
    applyStimulus(32'h3E800000, 2, 32'd0, 1.3181161, 0, 0);
    applyStimulus(32'hBF400000, 2, 32'd0, 2.4188584, 0, 0);
    applyStimulus(32'h3F7FFFFF, 0, 32'd0, 0.0, 0, 0);

    applyStimulus(32'h3F000000, 2, 32'd0, 1.0471976, 3, 11);

    resetMidRequest(32'h3F666666, 5);
    applyStimulus(32'h00000000, 1, HALF_PI_BITS, 0.0, 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
